sequence_generator_moore: RTL
=============================

Name: sequence_generator_moore

Overview:
- Serial pattern transmitter that drives bit streams into the Moore sequence detector. It is the transmit end of the same 1-bit serial interface.
- Captures a DATA_W-bit pattern and serializes it MSB-first, one bit per clock, REPEAT times, with a programmable idle gap between repetitions.
- Moore-style: every output is decoded from registered state only, never combinationally from inputs.
- Used as stimulus/source block for detector bring-up and in-system loopback.

Parameters:
- DATA_W, 4, pattern width in bits (>=2).
- CNT_W, 8, width of repeat counter.
- GAP_W, 4, width of inter-repetition gap counter.
- IDLE_LEVEL, 1'b0, value driven on sequence_out when not shifting.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- pattern_in  input  DATA_W  pattern to transmit, MSB sent first.
- repeat_count  input  CNT_W  number of pattern repetitions; 0 means none.
- gap_cycles  input  GAP_W  idle cycles inserted between repetitions.
- sequence_out  output  1  serial bit stream; connects to detector sequence_in.
- bit_valid  output  1  high while sequence_out carries a pattern bit.
- busy  output  1  high in SHIFT and GAP.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async assert, sync release via the clock edge):
  - state = IDLE; sequence_out = IDLE_LEVEL; bit_valid = 0; busy = 0; done = 0.
  - All counters and shift register cleared.
- States: IDLE, SHIFT, GAP, DONE. Outputs by state:
  - IDLE: seq = IDLE_LEVEL, bit_valid = 0, busy = 0, done = 0.
  - SHIFT: seq = shreg[DATA_W-1], bit_valid = 1, busy = 1.
  - GAP: seq = IDLE_LEVEL, bit_valid = 0, busy = 1.
  - DONE: seq = IDLE_LEVEL, busy = 0, done = 1.
- IDLE with start = 1 at edge E0:
  - Capture pattern_in into shreg and into pat_hold, repeat_count into reps_left, gap_cycles into gap_hold.
  - Load bit_cnt = DATA_W-1.
  - If repeat_count != 0, go to SHIFT. The first bit (pattern MSB) is visible on sequence_out in the cycle after E0.
  - If repeat_count == 0, go to DONE. No bits are sent and bit_valid stays 0.
- SHIFT, each edge:
  - If bit_cnt != 0: shift shreg left by one, bit_cnt -= 1.
  - If bit_cnt == 0 (last bit of this repetition): reps_left -= 1, then:
    - reps_left was 1: go to DONE.
    - else gap_hold == 0: reload shreg = pat_hold, bit_cnt = DATA_W-1, stay in SHIFT. Back-to-back repetitions have no bubble.
    - else: gap_cnt = gap_hold-1, go to GAP.
- GAP: each edge decrement gap_cnt. When gap_cnt == 0, reload shreg and bit_cnt and go to SHIFT. The gap lasts exactly gap_hold cycles.
- DONE: lasts exactly one cycle, then IDLE. A start asserted during DONE is ignored. It is accepted from IDLE on the following cycle at the earliest.
- start in SHIFT, GAP or DONE is ignored. pattern_in, repeat_count and gap_cycles changes after capture have no effect.
- Total busy cycles = R*DATA_W + (R-1)*G, where R = repeat_count and G = gap_cycles.
- Counters never wrap. repeat_count = 2^CNT_W-1 is legal and runs to completion.
- reset_n asserted mid-SHIFT or mid-GAP: outputs go immediately (asynchronously) to reset values. No done pulse is produced. After release, the block sits in IDLE.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles with start = 1 -> sequence_out = 0, busy = 0, done = 0 throughout. After release, the block stays in IDLE until start is sampled.
- Single frame: pattern_in = 4'b1011, repeat_count = 1, gap = 0, start pulse -> sequence_out = 1,0,1,1 on the next 4 cycles with bit_valid = 1. Then done = 1 for exactly 1 cycle, then IDLE. A chained detector's output goes to 1 on the cycle after the fourth bit.
- Back-to-back: 4'b1011, repeat = 3, gap = 0 -> 12 contiguous valid bits 101110111011, busy high 12 cycles, one done pulse.
- Gapped: 4'b1101, repeat = 2, gap = 3 -> bits 1101, then three cycles of IDLE_LEVEL with bit_valid = 0, then 1101, then done. busy high for 11 cycles.
- Zero repeat and ignored start: repeat_count = 0 -> no valid bits and done on the cycle after the start edge. A second start pulsed mid-frame during a repeat = 2 run -> no change in bit count or timing.
- Mid-operation reset: assert reset_n low during the 2nd bit of a repeat = 4 frame -> outputs go to reset values within the same cycle. No done pulse. A new start after release transmits a full fresh frame from the MSB.

Source files
------------

// File: rtl/sequence_generator_moore.sv
// -----------------------------------------------------------------------------
// sequence_generator_moore
//
// Serial pattern transmitter, the transmit end of the 1-bit serial link that
// feeds the Moore sequence detector. A DATA_W-bit pattern is captured on a
// start request in IDLE. It is sent MSB-first, one bit per clock, repeat_count
// times, with gap_cycles idle cycles between consecutive repetitions.
//
// All outputs are registered and depend only on FSM state. They never follow
// the inputs combinationally.
//
// Ports:
//   clock        - system clock, rising edge
//   reset_n      - asynchronous active-low reset
//   start        - transmit request, only sampled in IDLE
//   pattern_in   - pattern to send, MSB first
//   repeat_count - number of repetitions (0 = finish without sending)
//   gap_cycles   - idle cycles inserted between repetitions
//   sequence_out - serial bit stream (to detector sequence_in)
//   bit_valid    - sequence_out carries a pattern bit
//   busy         - high while shifting or in an inter-repetition gap
//   done         - single-cycle completion pulse
// -----------------------------------------------------------------------------
module sequence_generator_moore #(
  parameter int   DATA_W     = 4,
  parameter int   CNT_W      = 8,
  parameter int   GAP_W      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern_in,
  input  logic [CNT_W-1:0]  repeat_count,
  input  logic [GAP_W-1:0]  gap_cycles,
  output logic              sequence_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              done
);

  localparam int BC_W = $clog2(DATA_W);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic [DATA_W-1:0]   pat_hold, pat_hold_n;
  logic [CNT_W-1:0]    reps_left, reps_left_n;
  logic [GAP_W-1:0]    gap_hold, gap_hold_n;
  logic [GAP_W-1:0]    gap_cnt, gap_cnt_n;
  logic [BC_W-1:0]     bit_cnt, bit_cnt_n;

  // Next-state and datapath update.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    pat_hold_n  = pat_hold;
    reps_left_n = reps_left;
    gap_hold_n  = gap_hold;
    gap_cnt_n   = gap_cnt;
    bit_cnt_n   = bit_cnt;

    case (state)
      IDLE: begin
        if (start) begin
          shreg_n     = pattern_in;
          pat_hold_n  = pattern_in;
          reps_left_n = repeat_count;
          gap_hold_n  = gap_cycles;
          bit_cnt_n   = BC_LAST;
          state_n     = (repeat_count != '0) ? SHIFT : DONE;
        end
      end

      SHIFT: begin
        if (bit_cnt != '0) begin
          shreg_n   = {shreg[DATA_W-2:0], 1'b0};
          bit_cnt_n = bit_cnt - BC_W'(1);
        end else begin
          // Last bit of this repetition is on the line now.
          reps_left_n = reps_left - CNT_W'(1);
          if (reps_left == CNT_W'(1)) begin
            state_n = DONE;
          end else if (gap_hold == '0) begin
            // Back-to-back: reload without a bubble cycle.
            shreg_n   = pat_hold;
            bit_cnt_n = BC_LAST;
          end else begin
            gap_cnt_n = gap_hold - GAP_W'(1);
            state_n   = GAP;
          end
        end
      end

      GAP: begin
        if (gap_cnt == '0) begin
          shreg_n   = pat_hold;
          bit_cnt_n = BC_LAST;
          state_n   = SHIFT;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State registers. The outputs are registered decodes of the next state,
  // so each output is a pure function of the state held in the flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      shreg        <= '0;
      pat_hold     <= '0;
      reps_left    <= '0;
      gap_hold     <= '0;
      gap_cnt      <= '0;
      bit_cnt      <= '0;
      sequence_out <= IDLE_LEVEL;
      bit_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      pat_hold  <= pat_hold_n;
      reps_left <= reps_left_n;
      gap_hold  <= gap_hold_n;
      gap_cnt   <= gap_cnt_n;
      bit_cnt   <= bit_cnt_n;

      case (state_n)
        SHIFT: begin
          sequence_out <= shreg_n[DATA_W-1];
          bit_valid    <= 1'b1;
          busy         <= 1'b1;
          done         <= 1'b0;
        end
        GAP: begin
          sequence_out <= IDLE_LEVEL;
          bit_valid    <= 1'b0;
          busy         <= 1'b1;
          done         <= 1'b0;
        end
        DONE: begin
          sequence_out <= IDLE_LEVEL;
          bit_valid    <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b1;
        end
        default: begin
          sequence_out <= IDLE_LEVEL;
          bit_valid    <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule
